// File: rtl/l2_req_scheduler.sv
// l2_req_scheduler: arbitrates I-side and D-side L1 requests onto a single L2 port.
// Latency: grant in IDLE, L2 request raised the next cycle, resp same cycle as L2_resp.
// Backpressure: one outstanding L2 transaction; a requester waits until granted.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   instr_read/write/addr/wdata       I-side request; instr_rdata/instr_resp back
//   data_read/write/addr/wdata        D-side request; data_rdata/data_resp back
//   L2_read/write/addr/wdata          request to L2; L2_rdata/L2_resp from L2
module l2_req_scheduler #(
   parameter int unsigned MAX_DATA_STREAK = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_read,
   input  logic         instr_write,
   input  logic [15:0]  instr_addr,
   input  logic [127:0] instr_wdata,
   output logic [127:0] instr_rdata,
   output logic         instr_resp,
   input  logic         data_read,
   input  logic         data_write,
   input  logic [15:0]  data_addr,
   input  logic [127:0] data_wdata,
   output logic [127:0] data_rdata,
   output logic         data_resp,
   output logic         L2_read,
   output logic         L2_write,
   output logic [15:0]  L2_addr,
   output logic [127:0] L2_wdata,
   input  logic [127:0] L2_rdata,
   input  logic         L2_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, GAP} state_t;

   localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

   state_t         state, state_nxt;
   logic [3:0]     streak, streak_nxt;
   logic [15:0]    hold_addr;
   logic [127:0]   hold_wdata;
   logic           hold_write;
   logic           instr_pend, data_pend;
   logic           grant_i, grant_d;

   assign instr_pend = instr_read | instr_write;
   assign data_pend  = data_read | data_write;

   // The L2 side only ever sees the latched copy of the granted request.
   assign L2_addr     = hold_addr;
   assign L2_wdata    = hold_wdata;
   assign instr_rdata = L2_rdata;
   assign data_rdata  = L2_rdata;

   always_comb begin
      state_nxt  = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      L2_read    = 1'b0;
      L2_write   = 1'b0;
      instr_resp = 1'b0;
      data_resp  = 1'b0;
      case (state)
         IDLE: begin
            if (instr_pend && data_pend) begin
               // Data wins ties until it has starved instr for MAX_DATA_STREAK grants.
               if (streak == MAX_STREAK) grant_i = 1'b1;
               else                      grant_d = 1'b1;
            end else if (instr_pend) begin
               grant_i = 1'b1;
            end else if (data_pend) begin
               grant_d = 1'b1;
            end
            if (grant_i)      state_nxt = SERVE_I;
            else if (grant_d) state_nxt = SERVE_D;
         end
         SERVE_I: begin
            L2_write = hold_write;
            L2_read  = ~hold_write;
            if (L2_resp) begin
               instr_resp = 1'b1;
               state_nxt  = GAP;
            end
         end
         SERVE_D: begin
            L2_write = hold_write;
            L2_read  = ~hold_write;
            if (L2_resp) begin
               data_resp = 1'b1;
               state_nxt = GAP;
            end
         end
         // One dead cycle so the L1 can drop a completed request before re-arbitration.
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      streak_nxt = streak;
      if (grant_i) begin
         streak_nxt = 4'd0;
      end else if (grant_d) begin
         if (!instr_pend)                streak_nxt = 4'd0;
         else if (streak >= MAX_STREAK)  streak_nxt = MAX_STREAK;
         else                            streak_nxt = streak + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         streak     <= 4'd0;
         hold_addr  <= 16'd0;
         hold_wdata <= 128'd0;
         hold_write <= 1'b0;
      end else begin
         state  <= state_nxt;
         streak <= streak_nxt;
         if (grant_i) begin
            hold_addr  <= instr_addr;
            hold_wdata <= instr_wdata;
            hold_write <= instr_write;
         end else if (grant_d) begin
            hold_addr  <= data_addr;
            hold_wdata <= data_wdata;
            hold_write <= data_write;
         end
      end
   end

endmodule
